// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// big-endian lane helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } lsu_state_e;

  // Size code 2'b11 behaves as a word, so only bit 1 matters here.
  function automatic logic isWord(input logic [1:0] sz);
    return sz[1];
  endfunction

  function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] off);
    if (sz[1]) return (off != 2'b00);
    if (sz == SZ_HALF) return off[0];
    return 1'b0;
  endfunction

  function automatic logic [7:0] laneByte(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [15:0] laneHalf(input logic [31:0] w, input logic h);
    return h ? w[15:0] : w[31:16];
  endfunction

endpackage

// File: rtl/lsu_lane_ctl.sv
// Combinational lane logic: extracts/extends load data and merges store data
// into the word read back from memory.
module lsu_lane_ctl
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  op_i,
  output logic [31:0] loadData_o,
  output logic [31:0] storeWord_o
);

  function automatic logic [31:0] extendLoad(input logic [31:0] rdata,
                                             input logic [1:0]  off,
                                             input logic [2:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    b = laneByte(rdata, off);
    h = laneHalf(rdata, off[1]);
    case (op[1:0])
      SZ_BYTE: return op[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return op[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] rdata,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [2:0]  op);
    logic [31:0] m;
    m = rdata;
    if (op[1:0] == SZ_BYTE) begin
      case (off)
        2'd0:    m[31:24] = wdata[7:0];
        2'd1:    m[23:16] = wdata[7:0];
        2'd2:    m[15:8]  = wdata[7:0];
        default: m[7:0]   = wdata[7:0];
      endcase
    end else if (op[1:0] == SZ_HALF) begin
      if (off[1]) m[15:0]  = wdata;
      else        m[31:16] = wdata;
    end
    return m;
  endfunction

  assign loadData_o  = extendLoad(rdata_i, offset_i, op_i);
  assign storeWord_o = mergeStore(rdata_i, wdata_i, offset_i, op_i);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request at a time, read-modify-write
// for sub-word stores, one response per accepted request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_misalign,
  output logic        resp_range,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [31:0] respData_q, respData_d;
  logic [4:0]  respRd_q, respRd_d;
  logic        respMis_q, respMis_d;
  logic        respRange_q, respRange_d;

  logic        reqMis, reqRange;
  logic [31:0] loadData, storeWord;

  assign reqMis   = isMisaligned(req_op[1:0], req_addr[1:0]);
  assign reqRange = (req_addr >= 32'(MEM_BYTES));

  lsu_lane_ctl u_lane (
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .offset_i    (addr_q[1:0]),
    .op_i        (op_q),
    .loadData_o  (loadData),
    .storeWord_o (storeWord)
  );

  // Response registers only change on entry to RESP so they hold otherwise.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    memWdata_d  = memWdata_q;
    respData_d  = respData_q;
    respRd_d    = respRd_q;
    respMis_d   = respMis_q;
    respRange_d = respRange_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata[15:0];
          rd_d    = req_rd;
          if (reqMis || reqRange) begin
            state_d     = S_RESP;
            respData_d  = 32'b0;
            respRd_d    = req_rd;
            respMis_d   = reqMis;
            respRange_d = !reqMis && reqRange;
          end else if (req_we && isWord(req_op[1:0])) begin
            state_d    = S_WR;
            memWdata_d = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (we_q) begin
          state_d    = S_WR;
          memWdata_d = storeWord;
        end else begin
          state_d     = S_RESP;
          respData_d  = loadData;
          respRd_d    = rd_q;
          respMis_d   = 1'b0;
          respRange_d = 1'b0;
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        respData_d  = 32'b0;
        respRd_d    = rd_q;
        respMis_d   = 1'b0;
        respRange_d = 1'b0;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      op_q        <= 3'b0;
      addr_q      <= 32'b0;
      wdata_q     <= 16'b0;
      rd_q        <= 5'b0;
      memWdata_q  <= 32'b0;
      respData_q  <= 32'b0;
      respRd_q    <= 5'b0;
      respMis_q   <= 1'b0;
      respRange_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      memWdata_q  <= memWdata_d;
      respData_q  <= respData_d;
      respRd_q    <= respRd_d;
      respMis_q   <= respMis_d;
      respRange_q <= respRange_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_data     = respData_q;
  assign resp_rd       = respRd_q;
  assign resp_misalign = respMis_q;
  assign resp_range    = respRange_q;
  assign mem_read      = (state_q == S_RD);
  assign mem_write     = (state_q == S_WR);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wdata     = memWdata_q;

endmodule
